if_id_ctrl: RTL and testbench
=============================

# if_id_ctrl

Fetch-side control and IF/ID pipeline register. The block consumes `pc`/`instr` from the fetch stage and drives that stage's control inputs: `instr_fetch_enable`, `branch_enable` and `imm_branch_offset`. It resolves branches in decode, squashes the wrong-path slot, honours downstream stalls, and stops fetch on HALT.

## Interface
- No parameters. Widths are fixed: PC 8 bits, instruction 16 bits, branch offset 6 bits.
- `clk` — in — 1 — single clock; all state updates on the rising edge.
- `rst` — in — 1 — reset, asynchronous and active-low.
- `pc` — in — 8 — current PC from the fetch stage.
- `instr` — in — 16 — instruction at `pc`. Valid the cycle after any cycle with `instr_fetch_enable`=1.
- `zero_flag` — in — 1 — condition flag from execute, sampled when a branch is in ID.
- `id_stall` — in — 1 — downstream stall; holds ID contents and fetch.
- `instr_fetch_enable` — out — 1 — fetch-stage PC advance / memory read enable.
- `branch_enable` — out — 1 — one-cycle redirect strobe to fetch.
- `imm_branch_offset` — out — 6 — signed offset fetch adds to its current `pc`.
- `id_valid`, `id_pc[7:0]`, `id_instr[15:0]` — out — IF/ID register contents.
- `halted` — out — 1 — HALT retired; fetch stopped.
- `branch_range_err` — out — 1 — one-cycle pulse; taken branch target not reachable.

## Operation
- **Decode:** opcode = `id_instr[15:12]`.
  - 4'hC = BEQZ, taken if `zero_flag`=1.
  - 4'hD = BNEZ, taken if `zero_flag`=0.
  - 4'hE = BR, always taken.
  - 4'hF = HALT.
  - imm6 = `id_instr[5:0]`, signed.
- **Target arithmetic:** 8-bit, wraps mod 256.
  - target = `id_pc` + 1 + sext(imm6).
  - diff = target − `pc`.
  - Reachable iff `diff[7:5]` are all equal. Then `imm_branch_offset` = `diff[5:0]`.
- **States:** BOOT, RUN, FLUSH, HALT.
  - **BOOT** (entered on reset): fetch_en=1, `id_valid`=0. Next state is RUN unconditionally.
  - **RUN:**
    - fetch_en = !`id_stall`.
    - If the previous cycle fetched and `id_stall`=0: capture `pc`/`instr` into ID and set `id_valid`=1. Otherwise hold ID.
    - **Taken branch** (`id_valid`, branch opcode true, `id_stall`=0, reachable): `branch_enable`=1 with offset, fetch_en=1, next state FLUSH.
    - **Unreachable taken branch:** `branch_range_err`=1, no redirect, treated as not-taken.
    - **HALT** in ID with `id_stall`=0: fetch_en=0, `id_valid` cleared next cycle, next state HALT.
  - **FLUSH:** the sequential slot arriving this cycle is discarded (`id_valid`=0). fetch_en=1, next state RUN.
  - **HALT:** `halted`=1, fetch_en=0, `branch_enable`=0. Only `rst` exits this state.
- `branch_enable` is never asserted while `id_stall`=1, in FLUSH, in HALT, or in BOOT.
- A branch in ID during FLUSH cannot occur, because ID is invalid in FLUSH.

## Timing
- **Reset values:**
  - `instr_fetch_enable`=1, `branch_enable`=0, `imm_branch_offset`=0.
  - `id_valid`=0, `id_pc`=0, `id_instr`=0.
  - `halted`=0, `branch_range_err`=0.
- `instr_fetch_enable`, `branch_enable` and `imm_branch_offset` are combinational from state, ID register, `zero_flag`, `id_stall` and `pc`. They are valid in the same cycle.
- **ID load latency:** one cycle after fetch.
- **Branch penalty:** exactly one squashed slot.
- **Stall:** ID is frozen and fetch_en=0 in the same cycle. Fetch resumes in the first cycle after `id_stall` falls.
- **Reset mid-FLUSH or in HALT:** asynchronous return to BOOT values; no pending branch survives.

## Configuration
- Macro: `IF_ID_BRANCH_STATS_EN`.
- **Defined:** adds outputs `taken_cnt[15:0]` and `squash_cnt[15:0]`.
  - Both reset to 0.
  - `taken_cnt` increments on each `branch_enable` cycle; `squash_cnt` increments on each FLUSH cycle.
  - Both saturate at 16'hFFFF.
- **Undefined:** the ports and counters are absent; all other behaviour is identical.

## Structure
- **Shared package `mips_pkg`:**
  - Opcode constants (OP_BEQZ, OP_BNEZ, OP_BR, OP_HALT).
  - Fetch state enum (BOOT/RUN/FLUSH/HALT).
  - Widths (PC_W=8, INSTR_W=16, OFF_W=6).
- **Sub-module `branch_offset_calc`** (combinational): `id_pc`, imm6, `pc` → offset[5:0] and reachable.

## Test plan
- Reset released: `instr_fetch_enable`=1 and `id_valid`=0 in BOOT. Instruction at pc=0 appears in ID one cycle later with `id_pc`=0.
- BR imm6=6'h3E at `id_pc`=8'h10, `pc`=8'h11: target 8'h0F, `branch_enable`=1, `imm_branch_offset`=6'h3E. The next slot is squashed (`id_valid`=0 for one cycle).
- BEQZ with `zero_flag`=0: no `branch_enable`, no squash. Same instruction with `zero_flag`=1: redirect plus one squash.
- `id_stall` held for 3 cycles with a branch in ID: `branch_enable` stays 0, ID is unchanged. The branch fires in the cycle after the stall drops.
- BR imm6=6'h1F at `id_pc`=8'h00, `pc`=8'hF0 (wrapped): diff out of range. `branch_range_err` pulses and no redirect occurs.
- HALT in ID: fetch_en=0 and `halted`=1 from the next cycle. Asserting `rst` low returns all outputs to reset values; fetch restarts from BOOT.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared fetch/decode definitions: opcode constants, fetch-control states and datapath widths.
package mips_pkg;

   localparam int PC_W    = 8;
   localparam int INSTR_W = 16;
   localparam int OFF_W   = 6;

   localparam logic [3:0] OP_BEQZ = 4'hC;
   localparam logic [3:0] OP_BNEZ = 4'hD;
   localparam logic [3:0] OP_BR   = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      HALT  = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/if_id_ctrl_if.sv
// Fetch <-> IF/ID control bus. The slave side is the controller; the master side is the fetch stage.
// IF_ID_BRANCH_STATS_EN adds the taken/squash statistics counters to the bus.
interface if_id_ctrl_if;

   logic [mips_pkg::PC_W-1:0]    pc;
   logic [mips_pkg::INSTR_W-1:0] instr;
   logic                         zero_flag;
   logic                         id_stall;
   logic                         instr_fetch_enable;
   logic                         branch_enable;
   logic [mips_pkg::OFF_W-1:0]   imm_branch_offset;
   logic                         id_valid;
   logic [mips_pkg::PC_W-1:0]    id_pc;
   logic [mips_pkg::INSTR_W-1:0] id_instr;
   logic                         halted;
   logic                         branch_range_err;
`ifdef IF_ID_BRANCH_STATS_EN
   logic [15:0]                  taken_cnt;
   logic [15:0]                  squash_cnt;
`endif

   modport slave (
      input  pc, instr, zero_flag, id_stall,
      output instr_fetch_enable, branch_enable, imm_branch_offset,
      output id_valid, id_pc, id_instr, halted, branch_range_err
`ifdef IF_ID_BRANCH_STATS_EN
      , output taken_cnt, squash_cnt
`endif
   );

   modport master (
      output pc, instr, zero_flag, id_stall,
      input  instr_fetch_enable, branch_enable, imm_branch_offset,
      input  id_valid, id_pc, id_instr, halted, branch_range_err
`ifdef IF_ID_BRANCH_STATS_EN
      , input taken_cnt, squash_cnt
`endif
   );

endinterface

// File: rtl/if_id_ctrl_branch_offset_calc.sv
// Branch target to fetch-relative offset conversion, with a check that the offset fits in 6 signed bits.
module branch_offset_calc
   import mips_pkg::*;
(
   input  logic [PC_W-1:0]  id_pc_i,
   input  logic [OFF_W-1:0] imm6_i,
   input  logic [PC_W-1:0]  pc_i,
   output logic [OFF_W-1:0] offset_o,
   output logic             reachable_o
);

   logic [PC_W-1:0] target;
   logic [PC_W-1:0] diff;

   assign target = id_pc_i + PC_W'(1) + {{(PC_W-OFF_W){imm6_i[OFF_W-1]}}, imm6_i};
   assign diff   = target - pc_i;

   // The offset fits when the bits above the 6-bit sign are copies of it.
   assign reachable_o = (diff[7:5] == 3'b000) || (diff[7:5] == 3'b111);
   assign offset_o    = diff[OFF_W-1:0];

endmodule

// File: rtl/if_id_ctrl.sv
// IF/ID register and fetch control: decode-stage branch resolution, one-slot squash, stall, HALT.
// Define IF_ID_BRANCH_STATS_EN to add saturating taken-branch and squash counters.
module if_id_ctrl
   import mips_pkg::*;
(
   input logic         clk,
   input logic         rst,
   if_id_ctrl_if.slave bus
);

   fetch_state_e       state_q, state_d;
   logic               fetched_q;
   logic               idValid_q, idValid_d;
   logic [PC_W-1:0]    idPc_q, idPc_d;
   logic [INSTR_W-1:0] idInstr_q, idInstr_d;

   logic [3:0]       opcode;
   logic [OFF_W-1:0] offset;
   logic             reachable;
   logic             taken;
   logic             haltInId;
   logic             fetchEn;
   logic             branchEn;
   logic             rangeErr;

   assign opcode   = idInstr_q[15:12];
   assign haltInId = idValid_q && (opcode == OP_HALT);

   branch_offset_calc uOffsetCalc (
      .id_pc_i     (idPc_q),
      .imm6_i      (idInstr_q[OFF_W-1:0]),
      .pc_i        (bus.pc),
      .offset_o    (offset),
      .reachable_o (reachable)
   );

   always_comb begin
      taken = 1'b0;
      case (opcode)
         OP_BEQZ: taken = idValid_q && bus.zero_flag;
         OP_BNEZ: taken = idValid_q && !bus.zero_flag;
         OP_BR:   taken = idValid_q;
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      fetchEn   = 1'b0;
      branchEn  = 1'b0;
      rangeErr  = 1'b0;
      idValid_d = idValid_q;
      idPc_d    = idPc_q;
      idInstr_d = idInstr_q;

      case (state_q)
         BOOT: begin
            fetchEn = 1'b1;
            state_d = RUN;
         end
         RUN: begin
            fetchEn = !bus.id_stall;
            if (!bus.id_stall && haltInId) begin
               fetchEn = 1'b0;
               state_d = HALT;
            end else if (!bus.id_stall && taken) begin
               if (reachable) begin
                  branchEn = 1'b1;
                  state_d  = FLUSH;
               end else begin
                  rangeErr = 1'b1;
               end
            end
         end
         FLUSH: begin
            fetchEn = 1'b1;
            state_d = RUN;
         end
         HALT: begin
            fetchEn = 1'b0;
         end
         default: state_d = BOOT;
      endcase

      // A redirect squashes the sequential slot now on the bus; HALT freezes ID for good.
      if (state_q != HALT) begin
         if ((state_d == HALT) || branchEn) begin
            idValid_d = 1'b0;
         end else if (fetched_q && !bus.id_stall) begin
            idValid_d = 1'b1;
            idPc_d    = bus.pc;
            idInstr_d = bus.instr;
         end
      end
   end

   // Reset counts as an issued fetch of pc 0, so BOOT's slot lands in ID straight away.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= BOOT;
         fetched_q <= 1'b1;
         idValid_q <= 1'b0;
         idPc_q    <= '0;
         idInstr_q <= '0;
      end else begin
         state_q   <= state_d;
         fetched_q <= fetchEn;
         idValid_q <= idValid_d;
         idPc_q    <= idPc_d;
         idInstr_q <= idInstr_d;
      end
   end

   assign bus.instr_fetch_enable = fetchEn;
   assign bus.branch_enable      = branchEn;
   assign bus.imm_branch_offset  = branchEn ? offset : '0;
   assign bus.id_valid           = idValid_q;
   assign bus.id_pc              = idPc_q;
   assign bus.id_instr           = idInstr_q;
   assign bus.halted             = (state_q == HALT);
   assign bus.branch_range_err   = rangeErr;

`ifdef IF_ID_BRANCH_STATS_EN
   logic [15:0] takenCnt_q;
   logic [15:0] squashCnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         takenCnt_q  <= '0;
         squashCnt_q <= '0;
      end else begin
         if (branchEn && (takenCnt_q != 16'hFFFF)) begin
            takenCnt_q <= takenCnt_q + 16'd1;
         end
         if ((state_q == FLUSH) && (squashCnt_q != 16'hFFFF)) begin
            squashCnt_q <= squashCnt_q + 16'd1;
         end
      end
   end

   assign bus.taken_cnt  = takenCnt_q;
   assign bus.squash_cnt = squashCnt_q;
`endif

endmodule

// File: tb/tb_if_id_ctrl.sv
// Self-checking bench for if_id_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_if_id_ctrl;
   import mips_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;

   if_id_ctrl_if bus();

   if_id_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checkCount = 0;
   int passCount  = 0;

   // Behavioural model: phase flags plus the IF/ID contents.
   bit          mBoot, mFlush, mHalt, mPrevFetch, mIdValid;
   logic [7:0]  mIdPc;
   logic [15:0] mIdInstr;
   bit          expFetch, expBr, expErr;
   logic [5:0]  expOff;

   function automatic void modelReset();
      mBoot = 1; mFlush = 0; mHalt = 0; mPrevFetch = 1;
      mIdValid = 0; mIdPc = 8'h00; mIdInstr = 16'h0000;
   endfunction

   // Expected combinational outputs for the current inputs and model contents.
   function automatic void modelEval();
      int op, imm, target, diff, sd;
      bit taken;
      op  = int'(mIdInstr[15:12]);
      imm = int'(mIdInstr[5:0]);
      if (imm >= 32) imm = imm - 64;
      target = (int'(mIdPc) + 1 + imm) & 255;
      diff   = (target - int'(bus.pc)) & 255;
      sd     = (diff >= 128) ? diff - 256 : diff;
      taken  = mIdValid && ((op == 12 && bus.zero_flag) || (op == 13 && !bus.zero_flag) || op == 14);
      expFetch = 0; expBr = 0; expErr = 0; expOff = 6'h00;
      if (mHalt) begin
         expFetch = 0;
      end else if (mBoot || mFlush) begin
         expFetch = 1;
      end else if (bus.id_stall) begin
         expFetch = 0;
      end else if (mIdValid && op == 15) begin
         expFetch = 0;
      end else begin
         expFetch = 1;
         if (taken) begin
            if (sd >= -32 && sd <= 31) begin
               expBr = 1; expOff = 6'(sd);
            end else begin
               expErr = 1;
            end
         end
      end
   endfunction

   function automatic void modelClock();
      bit haltNow;
      modelEval();
      if (mHalt) return;
      haltNow = !mBoot && !mFlush && !bus.id_stall && mIdValid && (mIdInstr[15:12] == 4'hF);
      if (haltNow) begin
         mHalt = 1; mIdValid = 0;
      end else if (expBr) begin
         mIdValid = 0;
      end else if (mPrevFetch && !bus.id_stall) begin
         mIdValid = 1; mIdPc = bus.pc; mIdInstr = bus.instr;
      end
      mFlush = expBr; mBoot = 0; mPrevFetch = expFetch;
   endfunction

   function automatic logic [15:0] randNop();
      logic [15:0] v;
      v = 16'($urandom);
      v[15:12] = 4'($urandom_range(0, 11));
      return v;
   endfunction

   task automatic applyStimulus(input logic [7:0] p, input logic [15:0] i, input bit z, input bit s);
      bus.pc = p; bus.instr = i; bus.zero_flag = z; bus.id_stall = s;
      #1;
      modelEval();
   endtask

   task automatic tick();
      @(posedge clk);
      modelClock();
      #1;
   endtask

   task automatic warmup();
      repeat (5) begin
         applyStimulus(8'($urandom), randNop(), 1'($urandom), 1'b0);
         tick();
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checkCount++; if (bus.instr_fetch_enable !== 1'b1) $display("[TB] FAIL rst_fetch: got %b want 1", bus.instr_fetch_enable); else passCount++;
      checkCount++; if (bus.branch_enable !== 1'b0) $display("[TB] FAIL rst_br: got %b want 0", bus.branch_enable); else passCount++;
      checkCount++; if (bus.imm_branch_offset !== 6'h00) $display("[TB] FAIL rst_off: got %h want 00", bus.imm_branch_offset); else passCount++;
      checkCount++; if (bus.id_valid !== 1'b0) $display("[TB] FAIL rst_valid: got %b want 0", bus.id_valid); else passCount++;
      checkCount++; if (bus.id_pc !== 8'h00 || bus.id_instr !== 16'h0000) $display("[TB] FAIL rst_id: got %h/%h want 00/0000", bus.id_pc, bus.id_instr); else passCount++;
      checkCount++; if (bus.halted !== 1'b0 || bus.branch_range_err !== 1'b0) $display("[TB] FAIL rst_flags: got %b%b want 00", bus.halted, bus.branch_range_err); else passCount++;
      rst = 1'b1;
      modelReset();
      applyStimulus(8'h00, 16'h1234, 1'b0, 1'b0);
      checkCount++; if (bus.instr_fetch_enable !== 1'b1 || bus.id_valid !== 1'b0) $display("[TB] FAIL boot: got fetch=%b valid=%b want 1/0", bus.instr_fetch_enable, bus.id_valid); else passCount++;
      tick();
      applyStimulus(8'h01, randNop(), 1'b0, 1'b0);
      checkCount++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 8'h00 || bus.id_instr !== 16'h1234) $display("[TB] FAIL first_load: got %b %h %h want 1 00 1234", bus.id_valid, bus.id_pc, bus.id_instr); else passCount++;
      tick();
   endtask

   task automatic test_branch_taken();
      warmup();
      applyStimulus(8'h10, 16'hE03E, 1'b0, 1'b0);
      tick();
      applyStimulus(8'h11, randNop(), 1'b0, 1'b0);
      checkCount++; if (bus.branch_enable !== 1'b1 || bus.imm_branch_offset !== 6'h3E) $display("[TB] FAIL br_redirect: got %b off=%h want 1 off=3e", bus.branch_enable, bus.imm_branch_offset); else passCount++;
      checkCount++; if (bus.instr_fetch_enable !== 1'b1) $display("[TB] FAIL br_fetch: got %b want 1", bus.instr_fetch_enable); else passCount++;
      tick();
      applyStimulus(8'h0F, randNop(), 1'b0, 1'b0);
      checkCount++; if (bus.id_valid !== 1'b0 || bus.branch_enable !== 1'b0) $display("[TB] FAIL br_squash: got valid=%b br=%b want 0/0", bus.id_valid, bus.branch_enable); else passCount++;
      tick();
      applyStimulus(8'h10, randNop(), 1'b0, 1'b0);
      checkCount++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 8'h0F) $display("[TB] FAIL br_target: got %b %h want 1 0f", bus.id_valid, bus.id_pc); else passCount++;
      tick();
   endtask

   task automatic test_beqz();
      warmup();
      applyStimulus(8'h20, 16'hC005, 1'b0, 1'b0);
      tick();
      applyStimulus(8'h21, 16'h0111, 1'b0, 1'b0);
      checkCount++; if (bus.branch_enable !== 1'b0 || bus.branch_range_err !== 1'b0) $display("[TB] FAIL beqz_nt: got br=%b err=%b want 0/0", bus.branch_enable, bus.branch_range_err); else passCount++;
      tick();
      applyStimulus(8'h22, 16'hC005, 1'b0, 1'b0);
      checkCount++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 8'h21) $display("[TB] FAIL beqz_nosquash: got %b %h want 1 21", bus.id_valid, bus.id_pc); else passCount++;
      tick();
      applyStimulus(8'h23, randNop(), 1'b1, 1'b0);
      checkCount++; if (bus.branch_enable !== 1'b1 || bus.imm_branch_offset !== 6'h05) $display("[TB] FAIL beqz_taken: got %b off=%h want 1 off=05", bus.branch_enable, bus.imm_branch_offset); else passCount++;
      tick();
      applyStimulus(8'h28, randNop(), 1'b1, 1'b0);
      checkCount++; if (bus.id_valid !== 1'b0) $display("[TB] FAIL beqz_squash: got %b want 0", bus.id_valid); else passCount++;
      tick();
   endtask

   task automatic test_stall();
      warmup();
      applyStimulus(8'h40, 16'hE002, 1'b0, 1'b0);
      tick();
      for (int c = 0; c < 3; c++) begin
         applyStimulus(8'h41, randNop(), 1'($urandom), 1'b1);
         checkCount++; if (bus.branch_enable !== 1'b0 || bus.instr_fetch_enable !== 1'b0) $display("[TB] FAIL stall_ctl: cycle %0d got br=%b fetch=%b want 0/0", c, bus.branch_enable, bus.instr_fetch_enable); else passCount++;
         checkCount++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 8'h40 || bus.id_instr !== 16'hE002) $display("[TB] FAIL stall_hold: got %b %h %h want 1 40 e002", bus.id_valid, bus.id_pc, bus.id_instr); else passCount++;
         tick();
      end
      applyStimulus(8'h41, randNop(), 1'b0, 1'b0);
      checkCount++; if (bus.branch_enable !== 1'b1 || bus.imm_branch_offset !== 6'h02) $display("[TB] FAIL stall_release: got %b off=%h want 1 off=02", bus.branch_enable, bus.imm_branch_offset); else passCount++;
      tick();
   endtask

   task automatic test_range_err();
      warmup();
      applyStimulus(8'h00, 16'hE01F, 1'b0, 1'b0);
      tick();
      applyStimulus(8'hF0, 16'h0AAA, 1'b0, 1'b0);
      checkCount++; if (bus.branch_range_err !== 1'b1 || bus.branch_enable !== 1'b0) $display("[TB] FAIL range_err: got err=%b br=%b want 1/0", bus.branch_range_err, bus.branch_enable); else passCount++;
      tick();
      applyStimulus(8'hF1, randNop(), 1'b0, 1'b0);
      checkCount++; if (bus.branch_range_err !== 1'b0 || bus.id_valid !== 1'b1 || bus.id_pc !== 8'hF0) $display("[TB] FAIL range_next: got err=%b %b %h want 0 1 f0", bus.branch_range_err, bus.id_valid, bus.id_pc); else passCount++;
      tick();
   endtask

   task automatic test_random();
      logic [7:0]  p;
      logic [15:0] i;
      for (int n = 0; n < 400; n++) begin
         i = 16'($urandom);
         if ($urandom_range(0, 1) == 1) i[15:12] = 4'($urandom_range(12, 14));
         else if (i[15:12] == 4'hF) i[15:12] = 4'h0;
         if ($urandom_range(0, 1) == 1) p = 8'(mIdPc + 8'd1 + 8'($urandom_range(0, 8)) - 8'd4);
         else p = 8'($urandom);
         applyStimulus(p, i, 1'($urandom), ($urandom_range(0, 3) == 0));
         checkCount++; if (bus.instr_fetch_enable !== expFetch) $display("[TB] FAIL rnd_fetch: n=%0d got %b want %b", n, bus.instr_fetch_enable, expFetch); else passCount++;
         checkCount++; if (bus.branch_enable !== expBr) $display("[TB] FAIL rnd_br: n=%0d got %b want %b", n, bus.branch_enable, expBr); else passCount++;
         checkCount++; if (bus.imm_branch_offset !== expOff) $display("[TB] FAIL rnd_off: n=%0d got %h want %h", n, bus.imm_branch_offset, expOff); else passCount++;
         checkCount++; if (bus.branch_range_err !== expErr) $display("[TB] FAIL rnd_err: n=%0d got %b want %b", n, bus.branch_range_err, expErr); else passCount++;
         checkCount++; if (bus.id_valid !== mIdValid) $display("[TB] FAIL rnd_valid: n=%0d got %b want %b", n, bus.id_valid, mIdValid); else passCount++;
         checkCount++; if (bus.id_pc !== mIdPc || bus.id_instr !== mIdInstr) $display("[TB] FAIL rnd_id: n=%0d got %h/%h want %h/%h", n, bus.id_pc, bus.id_instr, mIdPc, mIdInstr); else passCount++;
         checkCount++; if (bus.halted !== mHalt) $display("[TB] FAIL rnd_halted: n=%0d got %b want %b", n, bus.halted, mHalt); else passCount++;
         tick();
      end
   endtask

   task automatic test_reset_in_flush();
      warmup();
      applyStimulus(8'h60, 16'hE005, 1'b0, 1'b0);
      tick();
      applyStimulus(8'h61, randNop(), 1'b0, 1'b0);
      checkCount++; if (bus.branch_enable !== 1'b1) $display("[TB] FAIL flushrst_br: got %b want 1", bus.branch_enable); else passCount++;
      tick();
      rst = 1'b0;
      #1;
      checkCount++; if (bus.branch_enable !== 1'b0 || bus.instr_fetch_enable !== 1'b1 || bus.id_valid !== 1'b0 || bus.id_pc !== 8'h00) $display("[TB] FAIL flushrst_vals: got br=%b fetch=%b valid=%b pc=%h want 0 1 0 00", bus.branch_enable, bus.instr_fetch_enable, bus.id_valid, bus.id_pc); else passCount++;
      #1;
      rst = 1'b1;
      modelReset();
      applyStimulus(8'h00, 16'h0BCD, 1'b0, 1'b0);
      tick();
      applyStimulus(8'h01, randNop(), 1'b0, 1'b0);
      checkCount++; if (bus.id_valid !== 1'b1 || bus.id_instr !== 16'h0BCD || bus.branch_enable !== 1'b0) $display("[TB] FAIL flushrst_boot: got %b %h br=%b want 1 0bcd 0", bus.id_valid, bus.id_instr, bus.branch_enable); else passCount++;
      tick();
   endtask

   task automatic test_halt();
      warmup();
      applyStimulus(8'h50, 16'hF000, 1'b0, 1'b0);
      tick();
      applyStimulus(8'h51, randNop(), 1'b0, 1'b0);
      checkCount++; if (bus.instr_fetch_enable !== 1'b0 || bus.halted !== 1'b0) $display("[TB] FAIL halt_decode: got fetch=%b halted=%b want 0/0", bus.instr_fetch_enable, bus.halted); else passCount++;
      tick();
      for (int c = 0; c < 3; c++) begin
         applyStimulus(8'h52, 16'hE001, 1'($urandom), 1'b0);
         checkCount++; if (bus.halted !== 1'b1 || bus.instr_fetch_enable !== 1'b0 || bus.id_valid !== 1'b0 || bus.branch_enable !== 1'b0) $display("[TB] FAIL halt_hold: cycle %0d got h=%b f=%b v=%b br=%b want 1 0 0 0", c, bus.halted, bus.instr_fetch_enable, bus.id_valid, bus.branch_enable); else passCount++;
         tick();
      end
      rst = 1'b0;
      #1;
      checkCount++; if (bus.halted !== 1'b0 || bus.instr_fetch_enable !== 1'b1 || bus.id_valid !== 1'b0 || bus.id_pc !== 8'h00 || bus.id_instr !== 16'h0000) $display("[TB] FAIL halt_reset: got h=%b f=%b v=%b %h %h want 0 1 0 00 0000", bus.halted, bus.instr_fetch_enable, bus.id_valid, bus.id_pc, bus.id_instr); else passCount++;
      #1;
      rst = 1'b1;
      modelReset();
      applyStimulus(8'h00, 16'h0777, 1'b0, 1'b0);
      tick();
      applyStimulus(8'h01, randNop(), 1'b0, 1'b0);
      checkCount++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 8'h00 || bus.instr_fetch_enable !== 1'b1) $display("[TB] FAIL halt_restart: got %b %h f=%b want 1 00 1", bus.id_valid, bus.id_pc, bus.instr_fetch_enable); else passCount++;
      tick();
   endtask

   initial begin
      bus.pc = 8'h00; bus.instr = 16'h0000; bus.zero_flag = 1'b0; bus.id_stall = 1'b0;
      test_reset();
      test_branch_taken();
      test_beqz();
      test_stall();
      test_range_err();
      test_random();
      test_reset_in_flush();
      test_halt();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
